// File: rtl/r2sdf_bfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage for the streaming FFT.
// Optional macro BFLY_ROUND_EN: round-half-up with saturation when SCALE=1.
module r2sdf_bfly_stage #(
    parameter int DELAY_LEN = 8,
    parameter int SCALE     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [15:0] x_in_re,
    input  logic [15:0] x_in_im,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_phase,
    output logic [15:0] x_out_re,
    output logic [15:0] x_out_im,
    output logic        sync_err
);

    localparam int CW = $clog2(2 * DELAY_LEN);
    localparam logic [CW-1:0] HALF = CW'(DELAY_LEN);
    localparam logic [CW-1:0] LAST = CW'(2 * DELAY_LEN - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_eff;
    logic          primed;
    logic          accept;
    logic          mid_sof;
    logic          phase;

    logic [15:0] lane_re [DELAY_LEN];
    logic [15:0] lane_im [DELAY_LEN];
    logic [15:0] head_re;
    logic [15:0] head_im;

    logic [16:0] sum_re;
    logic [16:0] sum_im;
    logic [16:0] dif_re;
    logic [16:0] dif_im;
    logic [15:0] sum_re_s;
    logic [15:0] sum_im_s;
    logic [15:0] dif_re_s;
    logic [15:0] dif_im_s;

    // Scale a 17-bit exact butterfly result down to the 16-bit stream width.
    function automatic logic [15:0] scale_fn(input logic [16:0] v);
        logic [17:0] r;
        logic [16:0] t;
        logic [15:0] res;
        r   = {v[16], v};
        t   = v;
        res = v[15:0];
        if (SCALE == 1) begin
`ifdef BFLY_ROUND_EN
            r = r + 18'd1;
            t = r[17:1];
            if (!t[16] && t[15])
                res = 16'h7fff;
            else if (t[16] && !t[15])
                res = 16'h8000;
            else
                res = t[15:0];
`else
            res = v[16:1];
`endif
        end
        return res;
    endfunction

    assign accept  = enable & in_valid;
    assign cnt_eff = in_sof ? '0 : cnt;
    assign phase   = cnt_eff[CW-1];
    assign mid_sof = accept & in_sof & (cnt != '0);

    assign head_re = lane_re[DELAY_LEN-1];
    assign head_im = lane_im[DELAY_LEN-1];

    assign sum_re = {head_re[15], head_re} + {x_in_re[15], x_in_re};
    assign sum_im = {head_im[15], head_im} + {x_in_im[15], x_in_im};
    assign dif_re = {head_re[15], head_re} - {x_in_re[15], x_in_re};
    assign dif_im = {head_im[15], head_im} - {x_in_im[15], x_in_im};

    assign sum_re_s = scale_fn(sum_re);
    assign sum_im_s = scale_fn(sum_im);
    assign dif_re_s = scale_fn(dif_re);
    assign dif_im_s = scale_fn(dif_im);

    // Lane contents are masked by primed, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lane_re[0] <= phase ? dif_re_s : x_in_re;
            lane_im[0] <= phase ? dif_im_s : x_in_im;
            for (int i = 1; i < DELAY_LEN; i++) begin
                lane_re[i] <= lane_re[i-1];
                lane_im[i] <= lane_im[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_phase <= 1'b0;
            sync_err  <= 1'b0;
            x_out_re  <= '0;
            x_out_im  <= '0;
        end else if (enable) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                cnt      <= cnt_eff + ONE;
                sync_err <= mid_sof;
                if (mid_sof)
                    primed <= 1'b0;
                else if (cnt_eff == LAST)
                    primed <= 1'b1;
                if (!phase) begin
                    out_phase <= 1'b1;
                    // Differences of the previous frame drain out here.
                    if (primed && !mid_sof) begin
                        out_valid <= 1'b1;
                        x_out_re  <= head_re;
                        x_out_im  <= head_im;
                    end
                end else begin
                    out_phase <= 1'b0;
                    out_valid <= 1'b1;
                    out_sof   <= (cnt_eff == HALF);
                    x_out_re  <= sum_re_s;
                    x_out_im  <= sum_im_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_r2sdf_bfly_stage.sv
// Directed testbench for r2sdf_bfly_stage (DELAY_LEN=4, SCALE=1).
// Expected values are hand-derived butterfly results.
module tb_r2sdf_bfly_stage;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [15:0] x_in_re = '0;
    logic [15:0] x_in_im = '0;
    logic        out_valid;
    logic        out_sof;
    logic        out_phase;
    logic [15:0] x_out_re;
    logic [15:0] x_out_im;
    logic        sync_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    r2sdf_bfly_stage #(.DELAY_LEN(D), .SCALE(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .in_valid(in_valid),
        .in_sof(in_sof),
        .x_in_re(x_in_re),
        .x_in_im(x_in_im),
        .out_valid(out_valid),
        .out_sof(out_sof),
        .out_phase(out_phase),
        .x_out_re(x_out_re),
        .x_out_im(x_out_im),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic send(input int re, input int im, input bit sof);
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b1;
        in_sof   = sof;
        x_in_re  = 16'(re);
        x_in_im  = 16'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        enable   = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable   = 1'($urandom);
            in_valid = 1'($urandom);
            in_sof   = 1'($urandom);
            x_in_re  = 16'($urandom);
            x_in_im  = 16'($urandom);
            @(negedge clk);
        end
        enable   = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, out_sof, out_phase, sync_err} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000",
                     {out_valid, out_sof, out_phase, sync_err});
        else
            pass_cnt++;
        total_cnt++;
        if ({x_out_re, x_out_im} !== 32'h0)
            $display("FAIL reset_data got %h want 0", {x_out_re, x_out_im});
        else
            pass_cnt++;
    endtask

    task automatic test_basic();
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(i, 0, i == 0);
            if (i < D) begin
                total_cnt++;
                if (out_valid !== 1'b0)
                    $display("FAIL basic_first_p0 i=%0d valid got %b want 0",
                             i, out_valid);
                else
                    pass_cnt++;
            end else begin
                e = 16'(i - 2);
                total_cnt++;
                if ({out_valid, out_phase, out_sof, x_out_re} !==
                    {1'b1, 1'b0, 1'(i == D), e})
                    $display("FAIL basic_sum i=%0d got v%b p%b s%b %0d want %0d",
                             i, out_valid, out_phase, out_sof,
                             $signed(x_out_re), $signed(e));
                else
                    pass_cnt++;
            end
        end
        for (int i = 0; i < D; i++) begin
            send(i, 0, i == 0);
            total_cnt++;
            if ({out_valid, out_phase, x_out_re} !== {1'b1, 1'b1, 16'hfffe})
                $display("FAIL basic_diff i=%0d got v%b p%b %0d want -2",
                         i, out_valid, out_phase, $signed(x_out_re));
            else
                pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++)
            send(i % 8, 0, (i % 8) == 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, out_sof, out_phase, sync_err, x_out_re, x_out_im} !== '0)
            $display("FAIL async_reset got v%b re %0d want 0",
                     out_valid, $signed(x_out_re));
        else
            pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i, 0, i == 0);
            if (i < D) begin
                total_cnt++;
                if (out_valid !== 1'b0)
                    $display("FAIL post_reset_p0 i=%0d got %b want 0",
                             i, out_valid);
                else
                    pass_cnt++;
            end else if (i == D) begin
                total_cnt++;
                if ({out_valid, out_sof, x_out_re} !== {1'b1, 1'b1, 16'd2})
                    $display("FAIL post_reset_sum got v%b s%b %0d want 2",
                             out_valid, out_sof, $signed(x_out_re));
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_gapped();
        logic [15:0] held;
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(i % 8, 0, (i % 8) == 0);
            if (i < D) begin
                total_cnt++;
                if (out_valid !== 1'b0)
                    $display("FAIL gap_p0 i=%0d got %b want 0", i, out_valid);
                else
                    pass_cnt++;
            end else begin
                e = (i < 8) ? 16'(i - 2) : 16'hfffe;
                total_cnt++;
                if ({out_valid, out_phase, x_out_re} !== {1'b1, 1'(i >= 8), e})
                    $display("FAIL gap_out i=%0d got v%b p%b %0d want %0d",
                             i, out_valid, out_phase,
                             $signed(x_out_re), $signed(e));
                else
                    pass_cnt++;
            end
            held = x_out_re;
            idle();
            total_cnt++;
            if ({out_valid, x_out_re} !== {1'b0, held})
                $display("FAIL gap_idle i=%0d got v%b %0d want v0 %0d",
                         i, out_valid, $signed(x_out_re), $signed(held));
            else
                pass_cnt++;
        end
    endtask

    task automatic test_extremes();
        int re_a [8] = '{32767, -32768, 32767, -32768,
                         32767, -32768, -32768, 32767};
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(re_a[i], (i == 0) ? 1 : 0, i == 0);
            if (i == 4) begin
                total_cnt++;
                if (x_out_re !== 16'h7fff)
                    $display("FAIL ext_sum_max got %0d want 32767",
                             $signed(x_out_re));
                else
                    pass_cnt++;
`ifdef BFLY_ROUND_EN
                e = 16'd1;
`else
                e = 16'd0;
`endif
                total_cnt++;
                if (x_out_im !== e)
                    $display("FAIL ext_sum_lsb got %0d want %0d",
                             $signed(x_out_im), $signed(e));
                else
                    pass_cnt++;
            end else if (i == 5) begin
                total_cnt++;
                if (x_out_re !== 16'h8000)
                    $display("FAIL ext_sum_min got %0d want -32768",
                             $signed(x_out_re));
                else
                    pass_cnt++;
            end
        end
        for (int i = 0; i < D; i++) begin
            send(0, 0, i == 0);
            if (i == 2) begin
                total_cnt++;
                if ({out_valid, x_out_re} !== {1'b1, 16'h7fff})
                    $display("FAIL ext_diff_pos got v%b %0d want 32767",
                             out_valid, $signed(x_out_re));
                else
                    pass_cnt++;
            end else if (i == 3) begin
`ifdef BFLY_ROUND_EN
                e = 16'h8001;
`else
                e = 16'h8000;
`endif
                total_cnt++;
                if ({out_valid, x_out_re} !== {1'b1, e})
                    $display("FAIL ext_diff_neg got v%b %0d want %0d",
                             out_valid, $signed(x_out_re), $signed(e));
                else
                    pass_cnt++;
            end
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        for (int i = 0; i < 16; i++)
            send(i % 8, 0, (i % 8) == 0);
        send(20, 0, 1'b1);
        total_cnt++;
        if (sync_err !== 1'b0)
            $display("FAIL sof_cnt0 sync_err got %b want 0", sync_err);
        else
            pass_cnt++;
        send(21, 0, 1'b0);
        send(10, 0, 1'b1);
        total_cnt++;
        if ({sync_err, out_valid} !== 2'b10)
            $display("FAIL sof_mid got err%b v%b want err1 v0",
                     sync_err, out_valid);
        else
            pass_cnt++;
        for (int i = 1; i < D; i++) begin
            send(10 + i, 0, 1'b0);
            total_cnt++;
            if ({sync_err, out_valid} !== 2'b00)
                $display("FAIL sof_after i=%0d got err%b v%b want 00",
                         i, sync_err, out_valid);
            else
                pass_cnt++;
        end
        send(14, 0, 1'b0);
        total_cnt++;
        if ({out_valid, out_sof, x_out_re} !== {1'b1, 1'b1, 16'd12})
            $display("FAIL sof_resync got v%b s%b %0d want 12",
                     out_valid, out_sof, $signed(x_out_re));
        else
            pass_cnt++;
        send(15, 0, 1'b0);
        total_cnt++;
        if ({out_valid, out_sof, x_out_re} !== {1'b1, 1'b0, 16'd13})
            $display("FAIL sof_resync2 got v%b s%b %0d want 13",
                     out_valid, out_sof, $signed(x_out_re));
        else
            pass_cnt++;
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 6; i++)
            send(i, 0, i == 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            enable   = 1'b0;
            in_valid = 1'b1;
            in_sof   = 1'b0;
            x_in_re  = 16'd99;
            @(posedge clk);
            #1;
            total_cnt++;
            if ({out_valid, out_phase, x_out_re} !== {1'b1, 1'b0, 16'd3})
                $display("FAIL en_hold c=%0d got v%b p%b %0d want v1 p0 3",
                         c, out_valid, out_phase, $signed(x_out_re));
            else
                pass_cnt++;
        end
        for (int i = 6; i < 8; i++) begin
            send(i, 0, 1'b0);
            total_cnt++;
            if ({out_valid, x_out_re} !== {1'b1, 16'(i - 2)})
                $display("FAIL en_resume i=%0d got v%b %0d want %0d",
                         i, out_valid, $signed(x_out_re), i - 2);
            else
                pass_cnt++;
        end
        for (int i = 0; i < D; i++) begin
            send(i, 0, i == 0);
            total_cnt++;
            if ({out_valid, out_phase, x_out_re} !== {1'b1, 1'b1, 16'hfffe})
                $display("FAIL en_diff i=%0d got v%b p%b %0d want -2",
                         i, out_valid, out_phase, $signed(x_out_re));
            else
                pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_gapped();
        test_extremes();
        test_sync_err();
        test_enable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
